// File: rtl/types_pkg.sv
// Shared types for the ALU exercise: the ALU operation encoding plus the
// arbiter's state type and sizing limits.
//
// Contents:
//   op_type       ALU operation selector (first literal is the reset value)
//   OP_RESET      value driven on alu_mode out of reset
//   ALU_ARB_MAX_REQ  upper bound on requesters sharing one ALU
//   arb_state_e   alu_arbiter FSM states
package types_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_type;

    localparam op_type OP_RESET = ADD;

    localparam int ALU_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin selector. Scans rr_ptr+1, rr_ptr+2, ... (mod
// NUM_REQ) and returns the first requester found.
//
// Ports:
//   req      in   per-requester request bits
//   rr_ptr   in   index of the most recent grant
//   any_req  out  at least one request bit set
//   grant    out  winning index (0 when any_req is low)
module alu_arbiter_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any_req,
    output logic [ID_W-1:0]    grant
);

    logic [ID_W-1:0] sel;

    // Walk from the farthest candidate back to the nearest so the nearest
    // set bit after rr_ptr is the last (and therefore winning) assignment.
    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        sel     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sel = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[sel]) begin
                any_req = 1'b1;
                grant   = sel;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters. One operation in flight: grant a
// requester round-robin, present its operands to the ALU, wait ALU_LATENCY
// cycles, capture result/correct and return them with a one-cycle rsp_valid.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   req / ack                 request (held until ack) / one-cycle accept pulse
//   req_value1/2, req_mode    per-requester operands and operation
//   rsp_valid                 one-cycle pulse to the granted requester
//   rsp_result, rsp_correct   last captured ALU outputs (held)
//   alu_value1/2, alu_mode    to the ALU, stable for the whole operation
//   alu_result, alu_correct   from the ALU
//   busy                      high whenever the FSM is not in IDLE
//   grant_count               per-requester accepted-op counters, saturating
//                             (only when ALU_ARBITER_STATS_EN is defined)
//
// state | meaning
// IDLE  | waiting for a request; grants on the edge one is seen
// EXEC  | operands on the ALU, counting down ALU_LATENCY
// RESP  | rsp_valid cycle; back to IDLE next edge
module alu_arbiter
    import types_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 2,
    parameter int ID_W        = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0][15:0]  req_value1,
    input  logic [NUM_REQ-1:0][15:0]  req_value2,
    input  op_type [NUM_REQ-1:0]      req_mode,
    output logic [NUM_REQ-1:0]        ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_result,
    output logic [15:0]               rsp_correct,
    output logic [15:0]               alu_value1,
    output logic [15:0]               alu_value2,
    output op_type                    alu_mode,
    input  logic [31:0]               alu_result,
    input  logic [15:0]               alu_correct,
    output logic                      busy
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]  grant_count
`endif
);

    localparam int CNT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;

    if (NUM_REQ < 2 || NUM_REQ > ALU_ARB_MAX_REQ) begin : g_bad_num_req
        $error("alu_arbiter: NUM_REQ out of range");
    end

    arb_state_e          state, state_d;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]     gnt_id, gnt_id_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [NUM_REQ-1:0]  ack_d, rsp_valid_d;
    logic [31:0]         rsp_result_d;
    logic [15:0]         rsp_correct_d;
    logic [15:0]         alu_value1_d, alu_value2_d;
    op_type              alu_mode_d;
    logic                any_req;
    logic [ID_W-1:0]     pick;

    alu_arbiter_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .grant   (pick)
    );

    always_comb begin
        state_d       = state;
        rr_ptr_d      = rr_ptr;
        gnt_id_d      = gnt_id;
        cnt_d         = cnt;
        ack_d         = '0;
        rsp_valid_d   = '0;
        rsp_result_d  = rsp_result;
        rsp_correct_d = rsp_correct;
        alu_value1_d  = alu_value1;
        alu_value2_d  = alu_value2;
        alu_mode_d    = alu_mode;
        case (state)
            IDLE: begin
                if (any_req) begin
                    ack_d[pick]  = 1'b1;
                    alu_value1_d = req_value1[pick];
                    alu_value2_d = req_value2[pick];
                    alu_mode_d   = req_mode[pick];
                    gnt_id_d     = pick;
                    rr_ptr_d     = pick;
                    cnt_d        = CNT_W'(ALU_LATENCY - 1);
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CNT_W'(1);
                end else begin
                    rsp_result_d        = alu_result;
                    rsp_correct_d       = alu_correct;
                    rsp_valid_d[gnt_id] = 1'b1;
                    state_d             = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            gnt_id      <= '0;
            cnt         <= '0;
            ack         <= '0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            rsp_correct <= '0;
            alu_value1  <= '0;
            alu_value2  <= '0;
            alu_mode    <= OP_RESET;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            gnt_id      <= gnt_id_d;
            cnt         <= cnt_d;
            ack         <= ack_d;
            rsp_valid   <= rsp_valid_d;
            rsp_result  <= rsp_result_d;
            rsp_correct <= rsp_correct_d;
            alu_value1  <= alu_value1_d;
            alu_value2  <= alu_value2_d;
            alu_mode    <= alu_mode_d;
            busy        <= (state_d != IDLE);
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ack_d[i] && grant_count[i] != 16'hFFFF) begin
                    grant_count[i] <= grant_count[i] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import types_pkg::*;

    localparam int NREQ = 4;
    localparam int LAT  = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ-1:0][15:0] req_value1 = '0;
    logic [NREQ-1:0][15:0] req_value2 = '0;
    op_type [NREQ-1:0]     req_mode = '{default: ADD};
    logic [NREQ-1:0]       ack, rsp_valid;
    logic [31:0]           rsp_result;
    logic [15:0]           rsp_correct;
    logic [15:0]           alu_value1, alu_value2;
    op_type                alu_mode;
    logic [31:0]           alu_result = '0;
    logic [15:0]           alu_correct = '0;
    logic                  busy;
`ifdef ALU_ARBITER_STATS_EN
    logic [NREQ-1:0][15:0] grant_count;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    alu_arbiter #(.NUM_REQ(NREQ), .ALU_LATENCY(LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_value1  (req_value1),
        .req_value2  (req_value2),
        .req_mode    (req_mode),
        .ack         (ack),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .rsp_correct (rsp_correct),
        .alu_value1  (alu_value1),
        .alu_value2  (alu_value2),
        .alu_mode    (alu_mode),
        .alu_result  (alu_result),
        .alu_correct (alu_correct),
        .busy        (busy)
`ifdef ALU_ARBITER_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input op_type m);
        case (m)
            ADD:     return 32'(a) + 32'(b);
            SUB:     return 32'(a) - 32'(b);
            MUL:     return 32'(a) * 32'(b);
            default: return (b == 16'd0) ? 32'd0 : 32'(a) / 32'(b);
        endcase
    endfunction

    function automatic logic [15:0] cor_fn(input logic [15:0] a, input logic [15:0] b, input op_type m);
        return a ^ b ^ {14'd0, m};
    endfunction

    // ALU stand-in: result valid one register stage after the operands settle,
    // so a capture at the end of the ALU_LATENCY window sees the right value.
    always @(posedge clock) begin
        alu_result  <= alu_fn(alu_value1, alu_value2, alu_mode);
        alu_correct <= cor_fn(alu_value1, alu_value2, alu_mode);
    end

    function automatic int oh_id(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int rr_next(input int last, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Leaves the bench at a falling edge with reset just released ("cycle 0").
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req = '1;
        for (int i = 0; i < NREQ; i++) begin
            req_value1[i] = 16'($urandom);
            req_value2[i] = 16'($urandom);
        end
        reset = 1'b0;
        repeat (6) @(negedge clock);
        apply_reset();
        tests_run++;
        if ({ack, rsp_valid, busy} !== 9'd0) begin
            tests_failed++;
            $display("FAIL reset_pulses got %0h exp 0", {ack, rsp_valid, busy});
        end
        tests_run++;
        if ({alu_value1, alu_value2, alu_mode} !== {16'd0, 16'd0, ADD}) begin
            tests_failed++;
            $display("FAIL reset_alu got %0h exp %0h", {alu_value1, alu_value2, alu_mode}, {16'd0, 16'd0, ADD});
        end
        tests_run++;
        if ({rsp_result, rsp_correct} !== 48'd0) begin
            tests_failed++;
            $display("FAIL reset_rsp got %0h exp 0", {rsp_result, rsp_correct});
        end
    endtask

    task automatic test_single();
        apply_reset();
        req_value1[0] = 16'd5;
        req_value2[0] = 16'd7;
        req_mode[0]   = ADD;
        req           = 4'b0001;
        @(negedge clock);
        tests_run++;
        if (ack !== 4'b0001 || busy !== 1'b1 || alu_value1 !== 16'd5 || alu_value2 !== 16'd7) begin
            tests_failed++;
            $display("FAIL single_ack got ack=%b busy=%b v1=%0d v2=%0d exp ack=0001 busy=1 v1=5 v2=7", ack, busy, alu_value1, alu_value2);
        end
        req = '0;
        @(negedge clock);
        tests_run++;
        if (ack !== 4'b0000 || rsp_valid !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_gap got ack=%b rsp_valid=%b exp 0000/0000", ack, rsp_valid);
        end
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 32'd12 || rsp_correct !== cor_fn(16'd5, 16'd7, ADD)) begin
            tests_failed++;
            $display("FAIL single_rsp got rsp_valid=%b result=%0d correct=%0h exp 0001/12/%0h", rsp_valid, rsp_result, rsp_correct, cor_fn(16'd5, 16'd7, ADD));
        end
        @(negedge clock);
        tests_run++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_result !== 32'd12) begin
            tests_failed++;
            $display("FAIL single_done got rsp_valid=%b busy=%b result=%0d exp 0000/0/12", rsp_valid, busy, rsp_result);
        end
    endtask

    task automatic test_all_hold();
        int acyc[$], aid[$], rcyc[$], rid[$];
        logic [31:0] rres[$];
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_value1[i] = 16'($urandom);
            req_value2[i] = 16'($urandom_range(255, 1));
            req_mode[i]   = op_type'($urandom_range(3, 0));
        end
        req = '1;
        for (int c = 0; c < 22; c++) begin
            if (ack != '0) begin acyc.push_back(c); aid.push_back(oh_id(ack)); end
            if (rsp_valid != '0) begin rcyc.push_back(c); rid.push_back(oh_id(rsp_valid)); rres.push_back(rsp_result); end
            @(negedge clock);
        end
        req = '0;
        tests_run++;
        if (acyc.size() < 5 || rcyc.size() < 5) begin
            tests_failed++;
            $display("FAIL hold_count got acks=%0d rsps=%0d exp at least 5 each", acyc.size(), rcyc.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (aid[k] !== k % NREQ || acyc[k] !== 1 + 4 * k) begin
                    tests_failed++;
                    $display("FAIL hold_ack%0d got id=%0d cyc=%0d exp id=%0d cyc=%0d", k, aid[k], acyc[k], k % NREQ, 1 + 4 * k);
                end
                tests_run++;
                if (rid[k] !== k % NREQ || rcyc[k] !== 3 + 4 * k ||
                    rres[k] !== alu_fn(req_value1[k % NREQ], req_value2[k % NREQ], req_mode[k % NREQ])) begin
                    tests_failed++;
                    $display("FAIL hold_rsp%0d got id=%0d cyc=%0d res=%0h exp id=%0d cyc=%0d res=%0h", k, rid[k], rcyc[k], rres[k],
                             k % NREQ, 3 + 4 * k, alu_fn(req_value1[k % NREQ], req_value2[k % NREQ], req_mode[k % NREQ]));
                end
            end
        end
    endtask

    task automatic test_rr_wrap();
        apply_reset();
        req = 4'b1000;
        @(negedge clock);
        tests_run++;
        if (ack !== 4'b1000) begin
            tests_failed++;
            $display("FAIL wrap_first got ack=%b exp 1000", ack);
        end
        req = 4'b1010;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clock);
            tests_run++;
            if (ack !== ((c == 5) ? 4'b0010 : 4'b0000)) begin
                tests_failed++;
                $display("FAIL wrap_cyc%0d got ack=%b exp %b", c, ack, (c == 5) ? 4'b0010 : 4'b0000);
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_value1[2] = 16'h4321;
        req = 4'b0100;
        @(negedge clock);
        tests_run++;
        if (ack !== 4'b0100) begin
            tests_failed++;
            $display("FAIL abort_ack got ack=%b exp 0100", ack);
        end
        req = '0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0 || alu_value1 !== 16'd0 || rsp_result !== 32'd0) begin
            tests_failed++;
            $display("FAIL abort_state got rsp_valid=%b busy=%b v1=%0h result=%0h exp 0000/0/0/0", rsp_valid, busy, alu_value1, rsp_result);
        end
        req = '1;
        @(negedge clock);
        tests_run++;
        if (ack !== 4'b0001) begin
            tests_failed++;
            $display("FAIL abort_next got ack=%b exp 0001", ack);
        end
        req = '0;
    endtask

    task automatic test_operand_stability();
        logic [31:0] exp_res;
        apply_reset();
        req_value1[1] = 16'h1234;
        req_value2[1] = 16'h0011;
        req_mode[1]   = SUB;
        exp_res       = alu_fn(16'h1234, 16'h0011, SUB);
        req = 4'b0010;
        @(negedge clock);
        req = '0;
        req_value1[1] = 16'hFFFF;
        for (int c = 1; c <= 4; c++) begin
            tests_run++;
            if (alu_value1 !== 16'h1234) begin
                tests_failed++;
                $display("FAIL stable_cyc%0d got v1=%0h exp 1234", c, alu_value1);
            end
            if (c == 3) begin
                tests_run++;
                if (rsp_valid !== 4'b0010 || rsp_result !== exp_res) begin
                    tests_failed++;
                    $display("FAIL stable_rsp got rsp_valid=%b result=%0h exp 0010/%0h", rsp_valid, rsp_result, exp_res);
                end
            end
            if (c == 4) begin
                req_value1[0] = 16'hAAAA;
                req = 4'b0001;
            end
            @(negedge clock);
        end
        req = '0;
        tests_run++;
        if (ack !== 4'b0001 || alu_value1 !== 16'hAAAA) begin
            tests_failed++;
            $display("FAIL stable_next got ack=%b v1=%0h exp 0001/aaaa", ack, alu_value1);
        end
    endtask

    // Cycle-level model built from the latency rules: a grant decided in
    // cycle c shows ack in c+1, rsp_valid in c+1+LAT, busy over c+1..c+1+LAT,
    // and the arbiter may grant again from cycle c+LAT+2.
    task automatic test_random(input int ncycles);
        int cyc, free_at, ack_cyc, rsp_cyc, busy_lo, busy_hi, gid, m_last;
        logic [15:0] s_v1, s_v2, e_v1, e_v2, p_cor, e_cor;
        op_type s_m, e_m;
        logic [31:0] p_res, e_res;
        logic [NREQ-1:0] e_ack, e_rv;
        logic e_busy;
        apply_reset();
        cyc = 0; free_at = 0; ack_cyc = -1; rsp_cyc = -1; busy_lo = -1; busy_hi = -2; gid = 0; m_last = NREQ - 1;
        s_v1 = '0; s_v2 = '0; s_m = ADD; e_v1 = '0; e_v2 = '0; e_m = ADD;
        p_res = '0; p_cor = '0; e_res = '0; e_cor = '0;
        for (int n = 0; n < ncycles; n++) begin
            e_ack = (cyc == ack_cyc) ? NREQ'(1 << gid) : '0;
            e_rv  = (cyc == rsp_cyc) ? NREQ'(1 << gid) : '0;
            if (cyc == ack_cyc) begin e_v1 = s_v1; e_v2 = s_v2; e_m = s_m; end
            if (cyc == rsp_cyc) begin e_res = p_res; e_cor = p_cor; end
            e_busy = (cyc >= busy_lo && cyc <= busy_hi);
            tests_run++;
            if (ack !== e_ack || rsp_valid !== e_rv || busy !== e_busy) begin
                tests_failed++;
                $display("FAIL rand_pulse cyc=%0d got ack=%b rsp_valid=%b busy=%b exp %b/%b/%b", cyc, ack, rsp_valid, busy, e_ack, e_rv, e_busy);
            end
            tests_run++;
            if ({alu_value1, alu_value2, alu_mode} !== {e_v1, e_v2, e_m} || {rsp_result, rsp_correct} !== {e_res, e_cor}) begin
                tests_failed++;
                $display("FAIL rand_data cyc=%0d got alu=%0h rsp=%0h exp alu=%0h rsp=%0h", cyc,
                         {alu_value1, alu_value2, alu_mode}, {rsp_result, rsp_correct}, {e_v1, e_v2, e_m}, {e_res, e_cor});
            end
            for (int i = 0; i < NREQ; i++) begin
                if (e_ack[i]) begin
                    req_value1[i] = 16'($urandom);
                    req_value2[i] = 16'($urandom);
                    req_mode[i]   = op_type'($urandom_range(3, 0));
                    req[i]        = 1'($urandom_range(1, 0));
                end else if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req_value1[i] = 16'($urandom);
                    req_value2[i] = 16'($urandom);
                    req_mode[i]   = op_type'($urandom_range(3, 0));
                    req[i]        = 1'b1;
                end
            end
            if (cyc >= free_at && req != '0) begin
                gid     = rr_next(m_last, req);
                m_last  = gid;
                s_v1    = req_value1[gid];
                s_v2    = req_value2[gid];
                s_m     = req_mode[gid];
                p_res   = alu_fn(s_v1, s_v2, s_m);
                p_cor   = cor_fn(s_v1, s_v2, s_m);
                ack_cyc = cyc + 1;
                rsp_cyc = cyc + 1 + LAT;
                busy_lo = cyc + 1;
                busy_hi = cyc + 1 + LAT;
                free_at = cyc + LAT + 2;
            end
            @(negedge clock);
            cyc++;
        end
        req = '0;
    endtask

`ifdef ALU_ARBITER_STATS_EN
    task automatic test_stats();
        int seen;
        apply_reset();
        seen = 0;
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (ack[2]) seen++;
            if (seen == 3) req = '0;
        end
        for (int i = 0; i < NREQ; i++) begin
            tests_run++;
            if (grant_count[i] !== ((i == 2) ? 16'd3 : 16'd0)) begin
                tests_failed++;
                $display("FAIL stats_count%0d got %0d exp %0d", i, grant_count[i], (i == 2) ? 3 : 0);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_hold();
        test_rr_wrap();
        test_reset_mid();
        test_operand_stability();
        test_random(600);
`ifdef ALU_ARBITER_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
